// File: rtl/bitblaster_pkg.sv
// Shared types and instruction-field constants for the bit-blaster sequencer.
package bitblaster_pkg;

    localparam int WORD_W    = 10;
    localparam int OP_HI_MSB = 9;
    localparam int OP_HI_LSB = 8;
    localparam int OP_FN_MSB = 3;
    localparam int OP_FN_LSB = 0;

    localparam logic [1:0] OP_HI_LD = 2'b00;
    localparam logic [3:0] FN_LD    = 4'b0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_CHECK
    } stream_state_t;

    // An ld instruction needs the following program word as its operand.
    function automatic logic is_ld(input logic [WORD_W-1:0] w);
        return (w[OP_HI_MSB:OP_HI_LSB] == OP_HI_LD) && (w[OP_FN_MSB:OP_FN_LSB] == FN_LD);
    endfunction

endpackage

// File: rtl/instr_streamer_prog_ram.sv
// Program store: one synchronous write port, one asynchronous read port.
module prog_ram
    import bitblaster_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WORD_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_streamer.sv
// Program sequencer: presents stored words on raw_data and strobes PKb once
// per processor timestep, advancing to the next instruction on LED_D.
module instr_streamer
    import bitblaster_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int SETUP     = 2,
    parameter int HOLD      = 3,
    parameter int MAX_STEPS = 4
) (
    input  logic                       CLOCK_50,
    input  logic                       Resetn,
    input  logic                       wr_en,
    input  logic [WORD_W-1:0]          wr_data,
    input  logic                       clear,
    input  logic                       start,
    input  logic                       LED_D,
    output logic [WORD_W-1:0]          raw_data,
    output logic                       PKb,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] prog_count,
    output logic                       full,
    output logic                       error
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int TMAX = (SETUP > HOLD) ? SETUP : HOLD;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int SW   = $clog2(MAX_STEPS + 1);

    stream_state_t     state, state_d;
    logic [CW-1:0]     rd_ptr;
    logic [TW-1:0]     tmr;
    logic [SW-1:0]     steps;
    logic              data_done;
    logic [WORD_W-1:0] cur_instr;
    logic [WORD_W-1:0] rdata;
    logic [AW-1:0]     raddr;

    logic go_start, wr_fire, clr_fire, err_set, err_clr;
    logic load_next, load_data, raw_zero, strobe;

    assign full = (prog_count == CW'(DEPTH));
    assign busy = (state != ST_IDLE);

    // Word 0 is fetched while idle so that start can present it immediately.
    assign raddr = (state == ST_IDLE) ? '0 : rd_ptr[AW-1:0];

    prog_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (CLOCK_50),
        .we    (wr_fire),
        .waddr (prog_count[AW-1:0]),
        .wdata (wr_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        state_d   = state;
        go_start  = 1'b0;
        wr_fire   = 1'b0;
        clr_fire  = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        load_next = 1'b0;
        load_data = 1'b0;
        raw_zero  = 1'b0;
        strobe    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    err_clr = 1'b1;
                    if (prog_count != '0) begin
                        go_start = 1'b1;
                        state_d  = ST_SETUP;
                    end else begin
                        err_set = 1'b1;
                    end
                end else if (clear) begin
                    clr_fire = 1'b1;
                    err_clr  = 1'b1;
                end else if (wr_en) begin
                    if (full) err_set = 1'b1;
                    else      wr_fire = 1'b1;
                end
            end
            ST_SETUP: begin
                if (tmr == TW'(SETUP - 1)) state_d = ST_STROBE;
            end
            ST_STROBE: begin
                strobe  = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (tmr == TW'(HOLD - 1)) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                state_d = ST_SETUP;
                if (LED_D) begin
                    if (rd_ptr == prog_count) state_d = ST_IDLE;
                    else                      load_next = 1'b1;
                end else if (steps == SW'(MAX_STEPS)) begin
                    err_set = 1'b1;
                    state_d = ST_IDLE;
                end else if (is_ld(cur_instr) && !data_done) begin
                    if (rd_ptr < prog_count) begin
                        load_data = 1'b1;
                    end else begin
                        raw_zero = 1'b1;
                        err_set  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state      <= ST_IDLE;
            PKb        <= 1'b1;
            tmr        <= '0;
            prog_count <= '0;
            error      <= 1'b0;
            rd_ptr     <= '0;
            steps      <= '0;
            data_done  <= 1'b0;
            raw_data   <= '0;
        end else begin
            state <= state_d;
            PKb   <= (state_d != ST_STROBE);
            tmr   <= (state_d != state) ? '0 : tmr + TW'(1);

            if (clr_fire)     prog_count <= '0;
            else if (wr_fire) prog_count <= prog_count + CW'(1);

            // A set in the same cycle as a clear wins (start on an empty program).
            if (err_set)      error <= 1'b1;
            else if (err_clr) error <= 1'b0;

            if (strobe) steps <= steps + SW'(1);

            if (go_start || load_next) begin
                raw_data  <= rdata;
                rd_ptr    <= go_start ? CW'(1) : rd_ptr + CW'(1);
                steps     <= '0;
                data_done <= 1'b0;
            end else if (load_data) begin
                raw_data  <= rdata;
                rd_ptr    <= rd_ptr + CW'(1);
                data_done <= 1'b1;
            end else if (raw_zero) begin
                raw_data <= '0;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (go_start || load_next) cur_instr <= rdata;
    end

endmodule

// File: doc/instr_streamer.md
# instr_streamer

Program sequencer that drives the 10-bit processor's external input side. It stores a short program of 10-bit words, presents each word on `raw_data`, and issues one active-low `PKb` step strobe per processor timestep. It advances on the processor's `LED_D` instruction-done flag. For `ld` instructions it supplies the following program word as the data operand, which replaces manual switch and pushbutton entry on the board.

## Interface
- `DEPTH`, 16: program memory words (power of 2, ≥2)
- `SETUP`, 2: cycles `raw_data` is stable before `PKb` falls (≥1)
- `HOLD`, 3: cycles after `PKb` rises before `LED_D` is sampled (≥1)
- `MAX_STEPS`, 4: strobes allowed per instruction before timeout
- `CLOCK_50` in 1: sole clock, all logic on rising edge
- `Resetn` in 1: synchronous, active-low reset
- `wr_en` in 1: append `wr_data` to program (IDLE only)
- `wr_data` in 10: program word
- `clear` in 1: empty program (IDLE only)
- `start` in 1: run program from word 0
- `LED_D` in 1: processor done flag, high when current instruction has completed
- `raw_data` out 10: word presented to processor data input (registered)
- `PKb` out 1: step strobe, low for exactly one cycle per step
- `busy` out 1: high outside IDLE
- `prog_count` out $clog2(DEPTH+1): stored words
- `full` out 1: `prog_count == DEPTH`
- `error` out 1: sticky fault flag, cleared by `clear`, `start` or reset

## Operation
- States: IDLE, SETUP, STROBE, HOLD, CHECK.
- **IDLE**
  - `wr_en` with `!full`: write `mem[prog_count]`, then `prog_count++`.
  - `wr_en` with `full`: word dropped, `error`←1.
  - `clear`: `prog_count`←0. `clear` has priority over `wr_en` in the same cycle.
  - `start` with `prog_count>0`: `rd_ptr`←1, `raw_data`←`mem[0]`, latch `mem[0]` as `cur_instr`, `steps`←0, `data_done`←0, then SETUP.
  - `start` with `prog_count==0`: `error`←1, stay IDLE.
  - `start` has priority over `wr_en` and `clear`.
- In non-IDLE states, `wr_en`, `clear` and `start` are ignored.
- **SETUP**: hold for `SETUP` cycles, then STROBE.
- **STROBE**: `PKb`=0 for one cycle, `steps++`, then HOLD.
- **HOLD**: hold for `HOLD` cycles, then CHECK.
- **CHECK** samples `LED_D`:
  - `LED_D`=1 and `rd_ptr==prog_count`: go to IDLE (program finished).
  - `LED_D`=1 otherwise: present `mem[rd_ptr]`, `rd_ptr++`, latch the new `cur_instr`, reset `steps`/`data_done`, go to SETUP.
  - `LED_D`=0 and `steps==MAX_STEPS`: `error`←1, go to IDLE (timeout).
  - `LED_D`=0, `cur_instr` is `ld` (bits[9:8]=00, [3:0]=0000), `!data_done`, `rd_ptr<prog_count`: present `mem[rd_ptr]`, `rd_ptr++`, `data_done`←1, go to SETUP.
  - `ld` data word missing (`rd_ptr==prog_count`): `raw_data`←0, `error`←1, go to SETUP (the step is still completed).
  - Any other case: `raw_data` unchanged, go to SETUP.
- `raw_data` changes only on the entry edge into SETUP (or on `Resetn`).
- Program memory survives a run, so `start` reruns the same program.

## Timing
- Reset values: `raw_data`=0, `PKb`=1, `busy`=0, `error`=0, `prog_count`=0, state IDLE. Memory contents are not reset and are unreadable at `prog_count`=0.
- `start` sampled at edge k:
  - `raw_data` valid from k+1.
  - `PKb` low in cycle k+1+`SETUP`.
  - CHECK in cycle k+2+`SETUP`+`HOLD`.
- Each step lasts `SETUP`+1+`HOLD`+1 cycles. With default parameters: 7 cycles.
- `Resetn` low mid-run: next edge forces IDLE, `PKb`=1, program emptied. No partial strobe is generated.
- `PKb` never low on two consecutive cycles. Minimum gap between strobes is `HOLD`+1+`SETUP` cycles.

## Structure
- Package `bitblaster_pkg` holds:
  - state enum `stream_state_t`
  - opcode field constants: `OP_HI`=[9:8], `OP_FN`=[3:0], `FN_LD`=4'b0000
  - `WORD_W`=10
- Sub-module `prog_ram`: single write port, asynchronous read, `DEPTH`×10. The top contains only the FSM, counters and pointers.

## Test plan
- Write 3 words (`ld R0`=0x000, data 0x155, `cp R1,R0`=0x101); model `LED_D` high after step 2, then after step 2 → `raw_data` sequence 0x000, 0x155, 0x101, 0x101; exactly 4 `PKb` pulses; `busy` falls; `error`=0.
- `addi R2,5` (0x265) alone; `LED_D` high after step 3 → 3 strobes, `raw_data` constant 0x265, return to IDLE.
- Program holds only `ld R0` → second step drives `raw_data`=0, `error`=1.
- `LED_D` held 0 → exactly 4 strobes, then `error`=1 and IDLE.
- 17 writes with `DEPTH`=16 → `full`=1, `prog_count`=16, `error`=1; `clear` → `prog_count`=0, `error`=0.
- `Resetn` low during HOLD of step 2 → next cycle `PKb`=1, `busy`=0, `raw_data`=0; a following `start` sets `error`=1 (program empty).
